// File: rtl/oqpsk_mod.sv
// oqpsk_mod: serial chip stream to offset-QPSK half-sine I/Q samples.
// I rail carries even chips, Q rail odd chips offset by one chip period.
module oqpsk_mod #(
  parameter int SPC = 4,
  parameter int W   = 5,
  parameter int AMP = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chip_in,
  input  logic         chip_valid,
  output logic         chip_ready,
  output logic [W-1:0] i_out,
  output logic [W-1:0] q_out,
  output logic         validation,
  input  logic         pret,
  output logic         busy,
  output logic         tx_done
);

  localparam int N  = 2 * SPC;
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LOAD_Q = PW'(SPC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nx;

  // Quarter-wave sin(pi*i/16) in Q16, indexed 0..8.
  function automatic int sin_q16(input int i);
    case (i)
      0:       return 0;
      1:       return 12785;
      2:       return 25080;
      3:       return 36410;
      4:       return 46341;
      5:       return 54491;
      6:       return 60547;
      7:       return 64277;
      8:       return 65536;
      default: return 0;
    endcase
  endfunction

  function automatic int lut_val(input int k);
    int     idx;
    longint prod;
    idx = k * (16 / N);
    if (idx > 8) idx = 16 - idx;
    prod = longint'(AMP) * longint'(sin_q16(idx)) + 64'sd32768;
    return int'(prod >>> 16);
  endfunction

  logic signed [W-1:0] lut [N];

  for (genvar g = 0; g < N; g++) begin : g_lut
    assign lut[g] = W'(lut_val(g));
  end

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_q;
  logic          act_i, act_q;
  logic          sgn_i, sgn_q;
  logic          act_i_nx, act_q_nx;
  logic          sgn_i_nx, sgn_q_nx;
  logic          emit, done_nx;
  logic          advance, at_i, at_q, at_load;

  logic signed [W-1:0] mag_i, mag_q;
  logic signed [W-1:0] samp_i, samp_q;

  assign advance = !validation || pret;
  assign at_i    = phase == '0;
  assign at_q    = phase == LOAD_Q;
  assign at_load = at_i || at_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (chip_ready) state_nx = RUN;
      RUN:     if (advance && at_load && !chip_valid) state_nx = FLUSH;
      FLUSH:   if (advance && at_load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // chip_ready is combinational on pret so the stall takes effect at once.
  always_comb begin
    chip_ready = 1'b0;
    busy       = state != IDLE;
    unique case (state)
      IDLE:    chip_ready = chip_valid && advance;
      RUN:     chip_ready = chip_valid && advance && at_load;
      default: chip_ready = 1'b0;
    endcase
    if (reset) chip_ready = 1'b0;
  end

  always_comb begin
    act_i_nx = act_i;
    act_q_nx = act_q;
    sgn_i_nx = sgn_i;
    sgn_q_nx = sgn_q;
    emit     = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (chip_ready) begin
          act_i_nx = 1'b1;
          act_q_nx = 1'b0;
          sgn_i_nx = chip_in;
          emit     = 1'b1;
        end
      end
      RUN: begin
        if (advance) begin
          emit = 1'b1;
          if (at_i) begin
            act_i_nx = chip_valid;
            if (chip_valid) sgn_i_nx = chip_in;
          end
          if (at_q) begin
            act_q_nx = chip_valid;
            if (chip_valid) sgn_q_nx = chip_in;
          end
        end
      end
      FLUSH: begin
        if (advance) begin
          if (at_load) begin
            act_i_nx = 1'b0;
            act_q_nx = 1'b0;
            done_nx  = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Q pulse lags I by SPC samples, so its LUT index is phase-SPC mod 2*SPC.
  assign phase_q = phase + LOAD_Q;
  assign mag_i   = lut[phase];
  assign mag_q   = lut[phase_q];
  assign samp_i  = !act_i_nx ? '0 : (sgn_i_nx ? mag_i : -mag_i);
  assign samp_q  = !act_q_nx ? '0 : (sgn_q_nx ? mag_q : -mag_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      act_i      <= 1'b0;
      act_q      <= 1'b0;
      sgn_i      <= 1'b0;
      sgn_q      <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      validation <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      act_i   <= act_i_nx;
      act_q   <= act_q_nx;
      sgn_i   <= sgn_i_nx;
      sgn_q   <= sgn_q_nx;
      tx_done <= done_nx;
      if (emit) begin
        i_out      <= samp_i;
        q_out      <= samp_q;
        validation <= 1'b1;
        phase      <= phase + PW'(1);
      end else if (done_nx) begin
        i_out      <= '0;
        q_out      <= '0;
        validation <= 1'b0;
        phase      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_oqpsk_mod.sv
// tb_oqpsk_mod: scoreboard bench for the OQPSK modulator.
// Expected samples are queued by stimulus and popped by a negedge monitor.
module tb_oqpsk_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_in;
  logic       chip_valid;
  logic       chip_ready;
  logic [4:0] i_out;
  logic [4:0] q_out;
  logic       validation;
  logic       pret;
  logic       busy;
  logic       tx_done;

  typedef struct {
    int i;
    int q;
  } samp_t;

  samp_t exp_q[$];

  int n_chk   = 0;
  int n_err   = 0;
  int n_pop   = 0;
  int n_done  = 0;
  int n_acc   = 0;
  int n_val   = 0;
  int cyc     = 0;
  int first_v = -1;
  int last_v  = -1;

  int lt [8] = '{0, 6, 11, 14, 15, 14, 11, 6};
  int i1 [12] = '{0, 6, 11, 14, 15, 14, 11, 6, 0, 0, 0, 0};
  int q1 [12] = '{0, 0, 0, 0, 0, -6, -11, -14, -15, -14, -11, -6};
  int i2 [8] = '{0, -6, -11, -14, -15, -14, -11, -6};

  oqpsk_mod #(
    .SPC(4),
    .W  (5),
    .AMP(15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chip_in   (chip_in),
    .chip_valid(chip_valid),
    .chip_ready(chip_ready),
    .i_out     (i_out),
    .q_out     (q_out),
    .validation(validation),
    .pret      (pret),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  function automatic int sg(input logic b);
    return b ? 1 : -1;
  endfunction

  // Model of one burst: I pulses from even chips, Q from odd chips +4.
  task automatic push_burst(input logic [31:0] bits, input int n);
    samp_t s;
    int e, o;
    for (int t = 0; t < 4 * (n + 1); t++) begin
      e = 2 * (t / 8);
      s.i = (e < n) ? sg(bits[e]) * lt[t % 8] : 0;
      s.q = 0;
      if (t >= 4) begin
        o = 2 * ((t - 4) / 8) + 1;
        s.q = (o < n) ? sg(bits[o]) * lt[(t - 4) % 8] : 0;
      end
      exp_q.push_back(s);
    end
  endtask

  always @(negedge clk) begin
    samp_t e;
    if (tx_done) n_done++;
    if (chip_ready) n_acc++;
    if (validation) begin
      n_val++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (validation && pret) begin
      chk("sample expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("i_out", int'($signed(i_out)), e.i);
        chk("q_out", int'($signed(q_out)), e.q);
      end
      n_pop++;
    end
  end

  task automatic send(input logic [31:0] bits, input int n);
    logic acc;
    int   t;
    for (int k = 0; k < n; k++) begin
      chip_in    = bits[k];
      chip_valid = 1'b1;
      t          = 0;
      do begin
        @(negedge clk);
        acc = chip_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      chk("chip accepted", int'(acc), 1);
    end
    chip_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int t = 0;
    while (n_done < target && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({nm, " done seen"}, int'(n_done >= target), 1);
    chk({nm, " queue left"}, exp_q.size(), 0);
    chk({nm, " busy after"}, int'(busy), 0);
    chk({nm, " valid after"}, int'(validation), 0);
    chk({nm, " tx_done 1cyc"}, int'(tx_done), 0);
  endtask

  initial begin
    int d0, a0, v0, p0, t;
    logic [31:0] bits;
    logic seen;

    reset      = 1'b1;
    chip_in    = 1'b0;
    chip_valid = 1'b0;
    pret       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst i_out", int'(i_out), 0);
    chk("rst q_out", int'(q_out), 0);
    chk("rst validation", int'(validation), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst tx_done", int'(tx_done), 0);
    chk("rst chip_ready", int'(chip_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: chips 1,0
    d0 = n_done;
    for (int k = 0; k < 12; k++) exp_q.push_back('{i1[k], q1[k]});
    send(32'b01, 2);
    wait_done(d0 + 1, "t1");
    chk("t1 tx_done count", n_done - d0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Test 2: single chip 0
    d0 = n_done;
    a0 = n_acc;
    for (int k = 0; k < 8; k++) exp_q.push_back('{i2[k], 0});
    send(32'b0, 1);
    wait_done(d0 + 1, "t2");
    chk("t2 ready count", n_acc - a0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Test 3: 32 chips 1,1,0,...
    bits = '0;
    for (int k = 0; k < 32; k++) bits[k] = (k % 3) != 2;
    d0      = n_done;
    v0      = n_val;
    first_v = -1;
    push_burst(bits, 32);
    send(bits, 32);
    wait_done(d0 + 1, "t3");
    chk("t3 valid cycles", n_val - v0, 132);
    chk("t3 no gaps", last_v - first_v + 1, 132);
    repeat (2) @(posedge clk);
    #1;

    // Test 4: 5-cycle stall with a chip waiting at the Q load point
    d0 = n_done;
    p0 = n_pop;
    push_burst(32'b0011, 4);
    fork
      send(32'b0011, 4);
      begin
        t = 0;
        while (n_pop < p0 + 3 && t < 200) begin
          @(posedge clk);
          #2;
          t++;
        end
        pret = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t4 hold i", int'($signed(i_out)), 14);
          chk("t4 hold q", int'($signed(q_out)), 0);
          chk("t4 hold valid", int'(validation), 1);
          chk("t4 hold ready", int'(chip_ready), 0);
          @(posedge clk);
          #2;
        end
        pret = 1'b1;
      end
    join
    wait_done(d0 + 1, "t4");
    repeat (2) @(posedge clk);
    #1;

    // Test 5: asynchronous reset mid-burst
    p0 = n_pop;
    push_burst(32'b1, 1);
    send(32'b1, 1);
    t = 0;
    while (n_pop < p0 + 6 && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    #1 reset = 1'b1;
    #1;
    chk("t5 async i_out", int'(i_out), 0);
    chk("t5 async q_out", int'(q_out), 0);
    chk("t5 async valid", int'(validation), 0);
    chk("t5 async busy", int'(busy), 0);
    chk("t5 async ready", int'(chip_ready), 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    d0 = n_done;
    push_burst(32'b1, 1);
    send(32'b1, 1);
    wait_done(d0 + 1, "t5");
    repeat (2) @(posedge clk);
    #1;

    // Test 6: chip raised during FLUSH waits for IDLE
    d0 = n_done;
    p0 = n_pop;
    push_burst(32'b0, 1);
    push_burst(32'b1, 1);
    send(32'b0, 1);
    t = 0;
    while (n_pop < p0 + 5 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chip_in    = 1'b1;
    chip_valid = 1'b1;
    seen       = 1'b0;
    t          = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
      else chk("t6 ready in flush", int'(chip_ready), 0);
      t++;
    end
    chk("t6 tx_done seen", int'(seen), 1);
    chk("t6 ready at done", int'(chip_ready), 1);
    @(posedge clk);
    #1 chip_valid = 1'b0;
    @(negedge clk);
    chk("t6 restart valid", int'(validation), 1);
    wait_done(d0 + 2, "t6");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/oqpsk_mod.md
Name: oqpsk_mod

Overview:
- Transmit-side counterpart of the iq_demod receive chain. Converts a serial ZigBee chip stream into offset-QPSK half-sine-shaped I/Q sample pairs.
- Produces samples on the same validation/pret handshake that the receive filter consumes, so the output can drive a DAC path or loop back into filter/iq_demod for self-test.
- Even chips drive the I rail; odd chips drive the Q rail, delayed by one chip period (Tc).

Parameters:
- SPC, 4, samples per chip period Tc. Legal values 2, 4, 8. The half-sine pulse length is 2*SPC samples.
- W, 5, output sample width, signed two's complement.
- AMP, 15, pulse peak amplitude. Must satisfy AMP <= 2^(W-1)-1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous reset, active-high
- chip_in  in  1  chip value: 1 maps to +pulse, 0 maps to -pulse
- chip_valid  in  1  chip_in is valid
- chip_ready  out  1  chip accepted this cycle when chip_valid is also 1
- i_out  out  W  I sample, signed
- q_out  out  W  Q sample, signed
- validation  out  1  i_out/q_out hold a valid sample
- pret  in  1  downstream ready
- busy  out  1  state is not IDLE
- tx_done  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - state=IDLE, phase=0.
  - i_out=0, q_out=0, validation=0, chip_ready=0, busy=0, tx_done=0.
  - Both rail-active flags cleared; any partial pulse is dropped.
- LUT:
  - 2*SPC constant entries, LUT[k] = round(AMP*sin(pi*k/(2*SPC))).
  - For the defaults: 0,6,11,14,15,14,11,6.
- advance = !validation || pret.
  - The output register updates only on advance.
  - While validation=1 and pret=0, i_out, q_out and validation hold stable and chip_ready=0.
- phase counter: 0..2*SPC-1, increments on each advance in RUN/FLUSH, wraps to 0.
- Load points:
  - phase==0 is the I load point; phase==SPC is the Q load point.
  - chip_ready = advance && chip_valid && state==RUN && at a load point. This is a combinational dependence on pret, by design.
  - A chip accepted at a load point sets that rail's sign and its active flag.
- Sample values:
  - i_out = I active ? sign_i*LUT[phase] : 0.
  - q_out = Q active ? sign_q*LUT[(phase-SPC) mod 2*SPC] : 0.
  - Negation is two's complement; no saturation is needed because AMP is bounded.
- IDLE:
  - chip_ready = chip_valid && advance.
  - On an accepted chip: I active, Q inactive, phase=0, and the sample for phase 0 (I=0, Q=0) is registered with validation=1 on the next edge. Go to RUN.
  - Latency from chip accepted to first valid sample is 1 cycle.
- RUN:
  - At a load point with chip_valid=1: the chip is accepted and the rail restarts its pulse.
  - At a load point with chip_valid=0: that rail is cleared (it outputs 0 from this sample on). Go to FLUSH.
  - During the first SPC samples of a burst, the Q rail is inactive and outputs 0.
- FLUSH:
  - chip_ready=0.
  - Continue emitting samples until the other rail completes its pulse, i.e. until the next load point of the cleared rail's counterpart.
  - On the advance that reaches that point: no new sample is produced, validation falls to 0, state goes to IDLE, and tx_done=1 for one cycle.
  - A chip presented during FLUSH stays pending and starts a new burst from IDLE.
- Boundaries:
  - If a burst has only one chip, the Q rail underruns at phase SPC. The burst then emits 2*SPC samples with q_out=0 throughout.
  - Continuous chips produce seamless wrap of phase with no bubbles when pret=1.

Test Plan:
1. Chips 1,0, then chip_valid=0; pret=1 constantly.
   - Exactly 12 samples.
   - i_out = 0,6,11,14,15,14,11,6,0,0,0,0.
   - q_out = 0,0,0,0,0,-6,-11,-14,-15,-14,-11,-6.
   - tx_done pulses once after the last sample; busy returns to 0.
2. Single chip 0 with pret=1.
   - 8 samples, i_out = 0,-6,-11,-14,-15,-14,-11,-6, q_out all 0.
   - chip_ready is asserted exactly once; tx_done follows.
3. Continuous stream 1,1,0,1,1,0,... (32 chips), pret=1.
   - validation stays high with no gaps; phase wraps every 8 samples.
   - i_out at phase 4 equals ±15 matching even chips; q_out at phase 0 equals ±15 matching odd chips.
4. Backpressure: pret held 0 for 5 cycles mid-pulse.
   - i_out, q_out and validation remain unchanged; chip_ready=0 throughout.
   - The sequence resumes with no sample lost or duplicated.
5. Assert reset at sample 6 of a burst.
   - All outputs are 0 in the same cycle without waiting for a clock edge.
   - After release, a new chip 1 restarts from i_out sequence 0,6,11,...
6. chip_valid raised during FLUSH.
   - Not accepted until IDLE; the new burst begins in the cycle after tx_done.
